// File: rtl/risc16_mc_control.sv
// ============================================================================
// risc16_mc_control : multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for RISC16
// Revision: 1.0
// ============================================================================
`default_nettype none

module risc16_mc_control (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [3:0] opcode,
  input  logic       zero,
  input  logic       mem_ack,
  output logic       mem_req,
  output logic       mem_we,
  output logic       mem_sel,
  output logic       ir_load,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic [1:0] alu_op,
  output logic       alu_src,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       retire,
  output logic       illegal
);

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_EXEC_R = 4'd2;
  localparam logic [3:0] S_WB_R   = 4'd3;
  localparam logic [3:0] S_ADDR   = 4'd4;
  localparam logic [3:0] S_MEM    = 4'd5;
  localparam logic [3:0] S_WB_L   = 4'd6;
  localparam logic [3:0] S_BRANCH = 4'd7;
  localparam logic [3:0] S_JUMP   = 4'd8;

  localparam logic [3:0] OP_LD  = 4'b0000;
  localparam logic [3:0] OP_ST  = 4'b0001;
  localparam logic [3:0] OP_BEQ = 4'b1011;
  localparam logic [3:0] OP_BNE = 4'b1100;
  localparam logic [3:0] OP_JMP = 4'b1101;

  logic [3:0] state;
  logic [3:0] next_state;
  logic [3:0] opc_reg;
  logic       pend;
  logic       set_illegal;

  // Every strobe is gated by rst_n so that asserting reset kills an
  // in-flight memory request without waiting for a clock edge.
  always_comb begin
    next_state  = state;
    set_illegal = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_sel     = 1'b0;
    ir_load     = 1'b0;
    pc_write    = 1'b0;
    pc_src      = 2'b00;
    alu_op      = 2'b00;
    alu_src     = 1'b0;
    reg_write   = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    retire      = 1'b0;
    if (rst_n) begin
      case (state)
        S_FETCH: begin
          mem_req = en | pend;
          if (mem_req && mem_ack) begin
            ir_load    = 1'b1;
            pc_write   = 1'b1;
            next_state = S_DECODE;
          end
        end
        S_DECODE: begin
          if (opcode == OP_LD || opcode == OP_ST) begin
            next_state = S_ADDR;
          end else if (opcode >= 4'b0010 && opcode <= 4'b1001) begin
            next_state = S_EXEC_R;
          end else if (opcode == OP_BEQ || opcode == OP_BNE) begin
            next_state = S_BRANCH;
          end else if (opcode == OP_JMP) begin
            next_state = S_JUMP;
          end else begin
            set_illegal = 1'b1;
            retire      = 1'b1;
            next_state  = S_FETCH;
          end
        end
        S_EXEC_R: next_state = S_WB_R;
        S_WB_R: begin
          reg_write  = 1'b1;
          reg_dst    = 1'b1;
          retire     = 1'b1;
          next_state = S_FETCH;
        end
        S_ADDR: begin
          alu_op     = 2'b10;
          alu_src    = 1'b1;
          next_state = S_MEM;
        end
        S_MEM: begin
          mem_req = 1'b1;
          mem_sel = 1'b1;
          mem_we  = (opc_reg == OP_ST);
          alu_op  = 2'b10;
          alu_src = 1'b1;
          if (mem_ack) begin
            if (opc_reg == OP_ST) begin
              retire     = 1'b1;
              next_state = S_FETCH;
            end else begin
              next_state = S_WB_L;
            end
          end
        end
        S_WB_L: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
          retire     = 1'b1;
          next_state = S_FETCH;
        end
        S_BRANCH: begin
          alu_op = 2'b01;
          if ((opc_reg == OP_BEQ && zero) || (opc_reg == OP_BNE && !zero)) begin
            pc_write = 1'b1;
            pc_src   = 2'b01;
          end
          retire     = 1'b1;
          next_state = S_FETCH;
        end
        S_JUMP: begin
          pc_write   = 1'b1;
          pc_src     = 2'b10;
          retire     = 1'b1;
          next_state = S_FETCH;
        end
        default: next_state = S_FETCH;
      endcase
    end
  end

  // The IR only shows the new opcode after the ir_load edge, so the local
  // copy is taken while in DECODE and used from then on.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_FETCH;
      pend    <= 1'b0;
      illegal <= 1'b0;
      opc_reg <= 4'd0;
    end else begin
      state <= next_state;
      if (state == S_FETCH) pend <= mem_req & ~mem_ack;
      if (state == S_DECODE) opc_reg <= opcode;
      if (set_illegal) illegal <= 1'b1;
    end
  end

endmodule

`default_nettype wire
